// File: rtl/key_cond_pkg.sv
// Shared types and constants for the key/reset conditioning block.
package key_cond_pkg;

  typedef enum logic [1:0] {
    POR_HOLD = 2'd0,
    RUN      = 2'd1,
    LP_HOLD  = 2'd2,
    WAIT_REL = 2'd3
  } rst_state_e;

  // Defaults sized for a 50 MHz system clock.
  localparam int unsigned DEF_NUM_KEYS          = 4;
  localparam int unsigned DEF_DEBOUNCE_CYCLES   = 500_000;
  localparam int unsigned DEF_LONG_PRESS_CYCLES = 100_000_000;
  localparam int unsigned DEF_RESET_HOLD_CYCLES = 1024;
  localparam int unsigned DEF_RESET_KEY         = 0;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, debounce counter, press/release pulses.
module key_debounce
  import key_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press,
  output logic released
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          sync_pressed;
  logic          level_d;
  logic [CW-1:0] cnt;

  // Synchroniser resets to the released (high) pin level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= key_n;
      sync_q2 <= sync_q1;
    end
  end

  assign sync_pressed = ~sync_q2;

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_pressed == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d  <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
    end else begin
      level_d  <= level;
      press    <= level & ~level_d;
      released <= ~level & level_d;
    end
  end

endmodule

// File: rtl/key_reset_conditioner.sv
// KEY conditioning plus SoC reset sequencer (power-on hold, long-press reset).
// Optional sticky press capture and irq enabled by KEY_RESET_COND_IRQ_EN.
module key_reset_conditioner
  import key_cond_pkg::*;
#(
  parameter int unsigned NUM_KEYS          = DEF_NUM_KEYS,
  parameter int unsigned DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int unsigned RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
  parameter int unsigned RESET_KEY         = DEF_RESET_KEY
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [NUM_KEYS-1:0] key_n_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                soc_reset_n,
  input  logic [NUM_KEYS-1:0] edge_clear,
  output logic [NUM_KEYS-1:0] edge_capture,
  output logic                irq
);

  localparam int unsigned KW = cnt_width(NUM_KEYS);
  localparam int unsigned HW = cnt_width(RESET_HOLD_CYCLES);
  localparam int unsigned PW = cnt_width(LONG_PRESS_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RESET_HOLD_CYCLES - 1);
  localparam logic [PW-1:0] PRESS_TRIP = PW'(LONG_PRESS_CYCLES);

  for (genvar i = 0; i < int'(NUM_KEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .key_n   (key_n_in[i]),
      .level   (key_level[i]),
      .press   (key_press[i]),
      .released(key_release[i])
    );
  end

  logic          rk_level;
  rst_state_e    state;
  rst_state_e    state_nx;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_cnt_nx;
  logic [PW-1:0] press_cnt;
  logic [PW-1:0] press_cnt_nx;
  logic          soc_reset_n_nx;

  assign rk_level = key_level[KW'(RESET_KEY)];

  // Sequencer is reset only by the board reset, never by its own output.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state       <= POR_HOLD;
      hold_cnt    <= '0;
      press_cnt   <= '0;
      soc_reset_n <= 1'b0;
    end else begin
      state       <= state_nx;
      hold_cnt    <= hold_cnt_nx;
      press_cnt   <= press_cnt_nx;
      soc_reset_n <= soc_reset_n_nx;
    end
  end

  // Counters clear by default, so every transition and every idle RUN cycle zeroes them.
  always_comb begin
    state_nx     = state;
    hold_cnt_nx  = '0;
    press_cnt_nx = '0;
    case (state)
      POR_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = RUN;
        else                       hold_cnt_nx = hold_cnt + HW'(1);
      end
      RUN: begin
        if (rk_level) begin
          if (press_cnt + PW'(1) == PRESS_TRIP) state_nx = LP_HOLD;
          else                                  press_cnt_nx = press_cnt + PW'(1);
        end
      end
      LP_HOLD: begin
        if (hold_cnt == HOLD_LAST) state_nx = WAIT_REL;
        else                       hold_cnt_nx = hold_cnt + HW'(1);
      end
      WAIT_REL: begin
        if (!rk_level) state_nx = RUN;
      end
      default: state_nx = POR_HOLD;
    endcase
    soc_reset_n_nx = (state_nx == RUN) || (state_nx == WAIT_REL);
  end

`ifdef KEY_RESET_COND_IRQ_EN
  logic [NUM_KEYS-1:0] capture_nx;

  // A press in the same cycle as its clear keeps the flag set.
  assign capture_nx = (edge_capture & ~edge_clear) | key_press;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      edge_capture <= '0;
      irq          <= 1'b0;
    end else begin
      edge_capture <= capture_nx;
      irq          <= |capture_nx;
    end
  end
`else
  logic unused_edge_clear;

  assign unused_edge_clear = ^edge_clear;
  assign edge_capture      = '0;
  assign irq               = 1'b0;
`endif

endmodule

// File: tb/tb_key_reset_conditioner.sv
// Randomised bench for key_reset_conditioner against a window-based reference model.
module tb_key_reset_conditioner;

  localparam int NK   = 4;
  localparam int DC   = 8;
  localparam int LP   = 64;
  localparam int HOLD = 16;
  localparam int RK   = 0;

  logic          clk;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] edge_clear;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] edge_capture;
  logic          soc_reset_n;
  logic          irq;

  key_reset_conditioner #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (DC),
    .LONG_PRESS_CYCLES(LP),
    .RESET_HOLD_CYCLES(HOLD),
    .RESET_KEY        (RK)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .key_n_in     (key_n),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .soc_reset_n  (soc_reset_n),
    .edge_clear   (edge_clear),
    .edge_capture (edge_capture),
    .irq          (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;
  int npress [NK];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key level flips once the synchronised samples (two cycles
  // late) have disagreed with it for DC consecutive cycles; the reset side is a
  // countdown of low cycles plus a run length of held reset-key cycles.
  bit [NK-1:0] m_level, m_level_d, m_press, m_rel, m_cap;
  bit          m_irq, m_soc_n, m_waiting;
  int          m_hold_left, m_lp_run;
  bit          m_hist [NK][DC+1];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_level = '0; m_level_d = '0; m_press = '0; m_rel = '0; m_cap = '0;
      m_irq = 1'b0; m_soc_n = 1'b0; m_waiting = 1'b0;
      m_hold_left = HOLD; m_lp_run = 0;
      for (int i = 0; i < NK; i++)
        for (int j = 0; j <= DC; j++) m_hist[i][j] = 1'b0;
    end else begin
      bit [NK-1:0] lvl_old;
      bit [NK-1:0] lvl_new;
      bit          diff_all;
      lvl_old = m_level;
`ifdef KEY_RESET_COND_IRQ_EN
      m_cap = (m_cap & ~edge_clear) | m_press;
      m_irq = |m_cap;
`endif
      m_press   = lvl_old & ~m_level_d;
      m_rel     = ~lvl_old & m_level_d;
      m_level_d = lvl_old;
      for (int i = 0; i < NK; i++) begin
        diff_all = 1'b1;
        for (int j = 1; j <= DC; j++)
          if (m_hist[i][j] == lvl_old[i]) diff_all = 1'b0;
        lvl_new[i] = diff_all ? ~lvl_old[i] : lvl_old[i];
        for (int j = DC; j >= 1; j--) m_hist[i][j] = m_hist[i][j-1];
        m_hist[i][0] = ~key_n[i];
      end
      m_level = lvl_new;
      if (m_hold_left > 0) begin
        m_hold_left--;
        if (m_hold_left == 0) m_soc_n = 1'b1;
      end else if (m_waiting) begin
        if (!lvl_old[RK]) m_waiting = 1'b0;
      end else if (lvl_old[RK]) begin
        m_lp_run++;
        if (m_lp_run == LP) begin
          m_lp_run = 0; m_hold_left = HOLD; m_soc_n = 1'b0; m_waiting = 1'b1;
        end
      end else begin
        m_lp_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      check("cycle_outputs",
            32'({key_level, key_press, key_release, edge_capture, soc_reset_n, irq}),
            32'({m_level, m_press, m_rel, m_cap, m_soc_n, m_irq}));
      for (int i = 0; i < NK; i++) if (key_press[i] === 1'b1) npress[i]++;
    end
  end

  task automatic wait_level(input int i, input bit val, output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (key_level[i] !== val && k < 100);
  endtask

  task automatic wait_soc(input bit val, output int k);
    k = 0;
    do begin @(negedge clk); k++; end while (soc_reset_n !== val && k < 200);
  endtask

  task automatic count_low(input int n, output int lows);
    lows = 0;
    repeat (n) begin @(negedge clk); if (soc_reset_n !== 1'b1) lows++; end
  endtask

  initial begin
    int k;
    int lows;
    int p0;
    rst_n = 1'b1; key_n = '1; edge_clear = '0;
    for (int i = 0; i < NK; i++) npress[i] = 0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    run_cmp = 1'b1;

    // Power-on hold
    #2 rst_n = 1'b1;
    wait_soc(1'b1, k);
    check("por_len", 32'(k), 32'd16);
    check("por_keys", 32'({key_level, key_press, key_release}), 32'd0);

    // Clean press/release on key 1
    @(negedge clk); key_n[1] = 1'b0;
    wait_level(1, 1'b1, k);
    check("press_lat", 32'(k), 32'd10);
    @(negedge clk); check("press_pulse", 32'(key_press), 32'h2);
    @(negedge clk); check("press_width", 32'(key_press), 32'h0);
    repeat (20) @(negedge clk);
    key_n[1] = 1'b1;
    wait_level(1, 1'b0, k);
    check("release_lat", 32'(k), 32'd10);
    @(negedge clk); check("release_pulse", 32'(key_release), 32'h2);
    @(negedge clk); check("release_width", 32'(key_release), 32'h0);

    // Bounce on key 2, then settle pressed
    p0 = npress[2];
    for (int j = 0; j < 14; j++) begin
      key_n[2] = j[0];
      repeat (3) @(negedge clk);
    end
    key_n[2] = 1'b0;
    wait_level(2, 1'b1, k);
    check("bounce_lat", 32'(k), 32'd10);
    check("bounce_quiet", 32'(npress[2] - p0), 32'd0);
    repeat (3) @(negedge clk);
    check("bounce_single", 32'(npress[2] - p0), 32'd1);
    key_n[2] = 1'b1;
    wait_level(2, 1'b0, k);

    // Long press of key 0 for 200 cycles
    @(negedge clk); key_n[0] = 1'b0;
    wait_level(0, 1'b1, k);
    check("lp_level_lat", 32'(k), 32'd10);
    wait_soc(1'b0, k);
    check("lp_delay", 32'(k), 32'd64);
    wait_soc(1'b1, k);
    check("lp_hold", 32'(k), 32'd16);
    count_low(110, lows);
    check("lp_no_repeat", 32'(lows), 32'd0);
    key_n[0] = 1'b1;
    wait_level(0, 1'b0, k);
    repeat (5) @(negedge clk);
    key_n[0] = 1'b0;
    wait_level(0, 1'b1, k);
    wait_soc(1'b0, k);
    check("lp_repress", 32'(k), 32'd64);
    wait_soc(1'b1, k);
    key_n[0] = 1'b1;
    wait_level(0, 1'b0, k);
    repeat (5) @(negedge clk);

    // Short press of key 0: no reset, run length cleared
    key_n[0] = 1'b0;
    count_low(40, lows);
    key_n[0] = 1'b1;
    count_low(60, k);
    check("short_no_reset", 32'(lows + k), 32'd0);
    key_n[0] = 1'b0;
    wait_level(0, 1'b1, k);
    wait_soc(1'b0, k);
    check("short_clears", 32'(k), 32'd64);
    wait_soc(1'b1, k);
    key_n[0] = 1'b1;
    wait_level(0, 1'b0, k);
    repeat (5) @(negedge clk);

`ifdef KEY_RESET_COND_IRQ_EN
    edge_clear = '1;
    @(negedge clk); edge_clear = '0;
    key_n[3] = 1'b0;
    wait_level(3, 1'b1, k);
    @(negedge clk);
    @(negedge clk);
    check("cap_set", 32'({edge_capture, irq}), 32'h11);
    edge_clear[3] = 1'b1;
    @(negedge clk); edge_clear = '0;
    check("cap_clear", 32'({edge_capture, irq}), 32'h00);
    key_n[3] = 1'b1;
    wait_level(3, 1'b0, k);
    key_n[3] = 1'b0;
    wait_level(3, 1'b1, k);
    @(negedge clk); edge_clear[3] = 1'b1;
    @(negedge clk); edge_clear = '0;
    check("cap_set_wins", 32'(edge_capture[3]), 32'd1);
    key_n[3] = 1'b1;
    wait_level(3, 1'b0, k);
`endif

    // Random phase with a mid-run board reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (c == 1500) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        wait_soc(1'b1, k);
        check("mid_por_len", 32'(k), 32'd16);
      end
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, (i == RK) ? 199 : 9) == 0) key_n[i] = ~key_n[i];
      edge_clear = ($urandom_range(0, 3) == 0) ? NK'($urandom_range(0, 15)) : '0;
    end
    edge_clear = '0;
    repeat (20) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
